// File: rtl/friscv_axil_io_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : friscv_axil_io_arbiter                                         |
// | Purpose : Two-master to one-slave AXI4-lite arbiter for the IO           |
// |           subsystem. Write (AW/W/B) and read (AR/R) paths are arbitrated |
// |           independently, one outstanding transaction per path. A grant   |
// |           is held until its response handshake completes.               |
// | Ports   : aclk, aresetn (async, active-low), srst (sync, active-high)    |
// |           slv0_* / slv1_* : AXI4-lite slave ports (from masters 0/1)     |
// |           mst_*           : AXI4-lite master port to the IO subsystem    |
// | Config  : FRISCV_ARB_ROUND_ROBIN_EN defined -> round-robin per path,     |
// |           otherwise port 0 has fixed priority.                           |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module friscv_axil_io_arbiter #(
  parameter int ADDRW = 16,
  parameter int DATAW = 128,
  parameter int IDW   = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               srst,
  // slave port 0
  input  logic               slv0_awvalid,
  output logic               slv0_awready,
  input  logic [ADDRW-1:0]   slv0_awaddr,
  input  logic [2:0]         slv0_awprot,
  input  logic [IDW-1:0]     slv0_awid,
  input  logic               slv0_wvalid,
  output logic               slv0_wready,
  input  logic [DATAW-1:0]   slv0_wdata,
  input  logic [DATAW/8-1:0] slv0_wstrb,
  output logic               slv0_bvalid,
  input  logic               slv0_bready,
  output logic [1:0]         slv0_bresp,
  output logic [IDW-1:0]     slv0_bid,
  input  logic               slv0_arvalid,
  output logic               slv0_arready,
  input  logic [ADDRW-1:0]   slv0_araddr,
  input  logic [2:0]         slv0_arprot,
  input  logic [IDW-1:0]     slv0_arid,
  output logic               slv0_rvalid,
  input  logic               slv0_rready,
  output logic [1:0]         slv0_rresp,
  output logic [DATAW-1:0]   slv0_rdata,
  output logic [IDW-1:0]     slv0_rid,
  // slave port 1
  input  logic               slv1_awvalid,
  output logic               slv1_awready,
  input  logic [ADDRW-1:0]   slv1_awaddr,
  input  logic [2:0]         slv1_awprot,
  input  logic [IDW-1:0]     slv1_awid,
  input  logic               slv1_wvalid,
  output logic               slv1_wready,
  input  logic [DATAW-1:0]   slv1_wdata,
  input  logic [DATAW/8-1:0] slv1_wstrb,
  output logic               slv1_bvalid,
  input  logic               slv1_bready,
  output logic [1:0]         slv1_bresp,
  output logic [IDW-1:0]     slv1_bid,
  input  logic               slv1_arvalid,
  output logic               slv1_arready,
  input  logic [ADDRW-1:0]   slv1_araddr,
  input  logic [2:0]         slv1_arprot,
  input  logic [IDW-1:0]     slv1_arid,
  output logic               slv1_rvalid,
  input  logic               slv1_rready,
  output logic [1:0]         slv1_rresp,
  output logic [DATAW-1:0]   slv1_rdata,
  output logic [IDW-1:0]     slv1_rid,
  // master port
  output logic               mst_awvalid,
  input  logic               mst_awready,
  output logic [ADDRW-1:0]   mst_awaddr,
  output logic [2:0]         mst_awprot,
  output logic [IDW-1:0]     mst_awid,
  output logic               mst_wvalid,
  input  logic               mst_wready,
  output logic [DATAW-1:0]   mst_wdata,
  output logic [DATAW/8-1:0] mst_wstrb,
  input  logic               mst_bvalid,
  output logic               mst_bready,
  input  logic [1:0]         mst_bresp,
  input  logic [IDW-1:0]     mst_bid,
  output logic               mst_arvalid,
  input  logic               mst_arready,
  output logic [ADDRW-1:0]   mst_araddr,
  output logic [2:0]         mst_arprot,
  output logic [IDW-1:0]     mst_arid,
  input  logic               mst_rvalid,
  output logic               mst_rready,
  input  logic [1:0]         mst_rresp,
  input  logic [DATAW-1:0]   mst_rdata,
  input  logic [IDW-1:0]     mst_rid
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2} rstate_t;

  wstate_t wstate_q;
  rstate_t rstate_q;
  logic    wgnt_q, rgnt_q;      // 0 = slv0 granted, 1 = slv1 granted
  logic    aw_done_q, w_done_q;
  logic    w_pick, r_pick;      // port that wins if arbitration happens now

  // ---------------- grant selection ----------------
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
  logic wlast_q, rlast_q;       // last granted port per path
  assign w_pick = (slv0_awvalid & slv1_awvalid) ? ~wlast_q : slv1_awvalid;
  assign r_pick = (slv0_arvalid & slv1_arvalid) ? ~rlast_q : slv1_arvalid;
`else
  assign w_pick = ~slv0_awvalid;
  assign r_pick = ~slv0_arvalid;
`endif

  // ---------------- state qualifiers (srst blanks outputs immediately) ----
  logic w_act, w_xfer, w_resp, r_act, r_addr, r_resp;
  assign w_act  = (wstate_q != W_IDLE) && !srst;
  assign w_xfer = (wstate_q == W_XFER) && !srst;
  assign w_resp = (wstate_q == W_RESP) && !srst;
  assign r_act  = (rstate_q != R_IDLE) && !srst;
  assign r_addr = (rstate_q == R_ADDR) && !srst;
  assign r_resp = (rstate_q == R_RESP) && !srst;

  // ---------------- write path mux ----------------
  logic aw_rdy, w_rdy, b_vld, b_hs, aw_hs, w_hs;

  assign mst_awvalid = w_xfer & ~aw_done_q & (wgnt_q ? slv1_awvalid : slv0_awvalid);
  assign mst_awaddr  = w_act ? (wgnt_q ? slv1_awaddr : slv0_awaddr) : '0;
  assign mst_awprot  = w_act ? (wgnt_q ? slv1_awprot : slv0_awprot) : '0;
  assign mst_awid    = w_act ? (wgnt_q ? slv1_awid   : slv0_awid)   : '0;
  assign mst_wvalid  = w_xfer & ~w_done_q & (wgnt_q ? slv1_wvalid : slv0_wvalid);
  assign mst_wdata   = w_act ? (wgnt_q ? slv1_wdata : slv0_wdata) : '0;
  assign mst_wstrb   = w_act ? (wgnt_q ? slv1_wstrb : slv0_wstrb) : '0;
  assign mst_bready  = w_resp & (wgnt_q ? slv1_bready : slv0_bready);

  assign aw_rdy       = w_xfer & mst_awready & ~aw_done_q;
  assign w_rdy        = w_xfer & mst_wready & ~w_done_q;
  assign b_vld        = w_resp & mst_bvalid;
  assign slv0_awready = aw_rdy & ~wgnt_q;
  assign slv1_awready = aw_rdy &  wgnt_q;
  assign slv0_wready  = w_rdy  & ~wgnt_q;
  assign slv1_wready  = w_rdy  &  wgnt_q;
  assign slv0_bvalid  = b_vld  & ~wgnt_q;
  assign slv1_bvalid  = b_vld  &  wgnt_q;
  assign slv0_bresp   = (w_resp & ~wgnt_q) ? mst_bresp : '0;
  assign slv1_bresp   = (w_resp &  wgnt_q) ? mst_bresp : '0;
  assign slv0_bid     = (w_resp & ~wgnt_q) ? mst_bid   : '0;
  assign slv1_bid     = (w_resp &  wgnt_q) ? mst_bid   : '0;

  assign aw_hs = mst_awvalid & mst_awready;
  assign w_hs  = mst_wvalid & mst_wready;
  assign b_hs  = mst_bvalid & mst_bready;

  // ---------------- read path mux ----------------
  logic ar_rdy, r_vld, ar_hs, r_hs;

  assign mst_arvalid = r_addr & (rgnt_q ? slv1_arvalid : slv0_arvalid);
  assign mst_araddr  = r_act ? (rgnt_q ? slv1_araddr : slv0_araddr) : '0;
  assign mst_arprot  = r_act ? (rgnt_q ? slv1_arprot : slv0_arprot) : '0;
  assign mst_arid    = r_act ? (rgnt_q ? slv1_arid   : slv0_arid)   : '0;
  assign mst_rready  = r_resp & (rgnt_q ? slv1_rready : slv0_rready);

  assign ar_rdy       = r_addr & mst_arready;
  assign r_vld        = r_resp & mst_rvalid;
  assign slv0_arready = ar_rdy & ~rgnt_q;
  assign slv1_arready = ar_rdy &  rgnt_q;
  assign slv0_rvalid  = r_vld  & ~rgnt_q;
  assign slv1_rvalid  = r_vld  &  rgnt_q;
  assign slv0_rresp   = (r_resp & ~rgnt_q) ? mst_rresp : '0;
  assign slv1_rresp   = (r_resp &  rgnt_q) ? mst_rresp : '0;
  assign slv0_rdata   = (r_resp & ~rgnt_q) ? mst_rdata : '0;
  assign slv1_rdata   = (r_resp &  rgnt_q) ? mst_rdata : '0;
  assign slv0_rid     = (r_resp & ~rgnt_q) ? mst_rid   : '0;
  assign slv1_rid     = (r_resp &  rgnt_q) ? mst_rid   : '0;

  assign ar_hs = mst_arvalid & mst_arready;
  assign r_hs  = mst_rvalid & mst_rready;

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      wgnt_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
      wlast_q   <= 1'b1;
`endif
    end else if (srst) begin
      wstate_q  <= W_IDLE;
      wgnt_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
      wlast_q   <= 1'b1;
`endif
    end else begin
      case (wstate_q)
        W_IDLE: begin
          // Only AW requests arbitration; an early W waits for its AW.
          if (slv0_awvalid || slv1_awvalid) begin
            wgnt_q   <= w_pick;
            wstate_q <= W_XFER;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
            wlast_q  <= w_pick;
`endif
          end
        end
        W_XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wstate_q <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q <= R_IDLE;
      rgnt_q   <= 1'b0;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
      rlast_q  <= 1'b1;
`endif
    end else if (srst) begin
      rstate_q <= R_IDLE;
      rgnt_q   <= 1'b0;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
      rlast_q  <= 1'b1;
`endif
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (slv0_arvalid || slv1_arvalid) begin
            rgnt_q   <= r_pick;
            rstate_q <= R_ADDR;
`ifdef FRISCV_ARB_ROUND_ROBIN_EN
            rlast_q  <= r_pick;
`endif
          end
        end
        R_ADDR:  if (ar_hs) rstate_q <= R_RESP;
        R_RESP:  if (r_hs)  rstate_q <= R_IDLE;
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/friscv_axil_io_arbiter.md
FRISCV_AXIL_IO_ARBITER -- requirements
Module: friscv_axil_io_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 16, address width.
REQ-002 SHALL have parameter DATAW, default 128, data width.
REQ-003 SHALL have parameter IDW, default 16, ID width.
REQ-004 SHALL have port aclk, input, 1 bit, single clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port srst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have, for each N in {0,1}, write address ports slvN_awvalid/awready/awaddr/awprot/awid, directions in/out/in/in/in, widths 1/1/ADDRW/3/IDW, AXI4-lite AW from master N.
REQ-008 SHALL have, for each N, write data ports slvN_wvalid/wready/wdata/wstrb, directions in/out/in/in, widths 1/1/DATAW/DATAW/8, AXI4-lite W.
REQ-009 SHALL have, for each N, write response ports slvN_bvalid/bready/bresp/bid, directions out/in/out/out, widths 1/1/2/IDW, AXI4-lite B.
REQ-010 SHALL have, for each N, read ports slvN_arvalid/arready/araddr/arprot/arid and slvN_rvalid/rready/rresp/rdata/rid, with AXI4-lite directions and widths 1/1/ADDRW/3/IDW and 1/1/2/DATAW/IDW.
REQ-011 SHALL have one master port mst_* carrying the same five channels, with mirrored directions, driving the IO subsystem slave port.

Function
REQ-012 SHALL arbitrate the write path (AW+W+B) and the read path (AR+R) independently; the two paths SHALL operate concurrently.
REQ-013 The write FSM SHALL have states W_IDLE, W_XFER and W_RESP.
REQ-014 In W_IDLE, when any slvN_awvalid=1, the write FSM SHALL register grant wgnt and move to W_XFER; it SHALL NOT assert any ready in that cycle.
REQ-015 mst_awvalid SHALL therefore rise one cycle after the request is sampled.
REQ-016 In W_XFER, AW and W SHALL be muxed combinationally from the granted port: mst_awvalid = slvG_awvalid & !aw_done, and slvG_awready = mst_awready & !aw_done; the W channel SHALL use the same scheme with w_done.
REQ-017 aw_done and w_done SHALL be set on their respective handshakes, in any order or in the same cycle; once both are set the write FSM SHALL move to W_RESP.
REQ-018 In W_RESP, mst_bvalid/bresp/bid SHALL route to the granted port and mst_bready = slvG_bready; on the B handshake the write FSM SHALL clear aw_done and w_done and return to W_IDLE.
REQ-019 The read FSM SHALL have states R_IDLE, R_ADDR and R_RESP, with grant, AR mux and R return behaving identically to REQ-014..018; it SHALL return to R_IDLE on the R handshake.
REQ-020 The non-granted port SHALL see awready, wready, arready, bvalid and rvalid all at 0 until it is granted.
REQ-021 Address, prot, data, strb, id and resp SHALL pass through unmodified; each path SHALL allow at most one outstanding transaction.
REQ-022 When one port requests, it SHALL be granted; simultaneous requests SHALL be resolved per REQ-029/030.
REQ-023 A grant SHALL be held until the transaction completes, regardless of the other port's requests.

Reset
REQ-024 On aresetn=0 (asynchronous) or srst=1 (synchronous), both FSMs SHALL return to IDLE and aw_done, w_done and the grants SHALL clear.
REQ-025 During reset, all mst_*valid, mst_bready, mst_rready, slvN_*ready, slvN_bvalid and slvN_rvalid SHALL be 0.
REQ-026 During reset, the round-robin pointers SHALL point to port 1 as last granted, so that port 0 wins first.
REQ-027 A reset mid-transaction SHALL abandon the transaction with no response issued to either port.
REQ-028 All muxed data outputs SHALL be 0 when no grant is active.

Configuration
REQ-029 With macro FRISCV_ARB_ROUND_ROBIN_EN defined, each path SHALL keep a last-granted bit; on simultaneous requests the port not last granted SHALL win, and the bit SHALL update on each grant.
REQ-030 Without FRISCV_ARB_ROUND_ROBIN_EN, port 0 SHALL have fixed priority on both paths and no pointer SHALL exist.

Verification
REQ-031 Bench SHALL check: after reset, slv0 writes awaddr=0x0010, wdata lane0=0xA5A5A5A5, awid=3 -> mst_awaddr=0x0010 one cycle later, then slv0_bvalid=1 with bid=3 and bresp=0.
REQ-032 Bench SHALL check (round-robin): slv0 and slv1 raise arvalid in the same cycle, twice -> slv0 is served first and slv1 second; on the third contention slv0 is served again.
REQ-033 Bench SHALL check (fixed priority build): both ports issue continuous reads -> slv1_arready stays 0 while slv0 keeps requesting.
REQ-034 Bench SHALL check: W presented 3 cycles before AW on slv1 -> a single master transaction with correct strb=0x000F, and exactly one B returned to slv1.
REQ-035 Bench SHALL check: slv0 write concurrent with slv1 read -> both complete with overlapping master AW and AR activity.
REQ-036 Bench SHALL check: aresetn is pulsed low while in W_RESP -> all valids are 0 immediately, and the next request from slv1 is granted normally.
